// File: rtl/layer0_writer_if.sv
// Layer-0 writer bus: producer handshake on the input side, result-memory
// write port plus status on the output side.
interface layer0_writer_if #(
    parameter int unsigned DW = 19
);
    localparam int unsigned CAW = 12;
    localparam int unsigned CDW = 20;
    localparam int unsigned SW  = 3;

    logic           i_start;
    logic           i_valid;
    logic [DW-1:0]  i_data_0;
    logic [DW-1:0]  i_data_1;
    logic           o_busy;
    logic           o_go_down;
    logic           o_cwr;
    logic [CAW-1:0] o_caddr_wr;
    logic [SW-1:0]  o_csel;
    logic [CDW-1:0] o_cdata_wr;
    logic           o_done;
    logic           o_overrun;

    // Producer / memory side (drives the results, observes the writes)
    modport master (
        output i_start, i_valid, i_data_0, i_data_1,
        input  o_busy, o_go_down, o_cwr, o_caddr_wr, o_csel, o_cdata_wr,
        input  o_done, o_overrun
    );

    // Writer side
    modport slave (
        input  i_start, i_valid, i_data_0, i_data_1,
        output o_busy, o_go_down, o_cwr, o_caddr_wr, o_csel, o_cdata_wr,
        output o_done, o_overrun
    );
endinterface

// File: rtl/layer0_writer.sv
// Layer-0 result sink: writes kernel-0 results on arrival, buffers kernel-1
// results for the row and flushes them once the row is complete.
module layer0_writer #(
    parameter int unsigned COLS = 64,
    parameter int unsigned ROWS = 64,
    parameter int unsigned DW   = 19,
    parameter logic [2:0]  SEL0 = 3'b001,
    parameter logic [2:0]  SEL1 = 3'b010
) (
    input  logic            clk,
    input  logic            reset,
    layer0_writer_if.slave  bus
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned CAW   = 12;
    localparam int unsigned CDW   = 20;
    localparam int unsigned SW    = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ROW     = 3'd1,
        S_FLUSH   = 3'd2,
        S_HANDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q,   row_d;
    logic [COL_W-1:0] col_q,   col_d;
    logic [COL_W-1:0] fidx_q,  fidx_d;

    logic             cwr_q,   cwr_d;
    logic [SW-1:0]    csel_q,  csel_d;
    logic [CAW-1:0]   caddr_q, caddr_d;
    logic [CDW-1:0]   cdata_q, cdata_d;
    logic             busy_q,  busy_d;
    logic             go_q,    go_d;
    logic             done_q,  done_d;
    logic             ovr_q,   ovr_d;

    logic             buf_we;
    logic [DW-1:0]    row_buf [COLS];
    logic [DW-1:0]    buf_rd;

    logic             last_col;
    logic             last_flush;
    logic             last_row;

    assign last_col   = (col_q  == COL_W'(COLS - 1));
    assign last_flush = (fidx_q == COL_W'(COLS - 1));
    assign last_row   = (row_q  == ROW_W'(ROWS - 1));
    assign buf_rd     = row_buf[fidx_q];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_ROW;
                end
            end
            S_ROW: begin
                if (bus.i_valid && last_col) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (last_flush) begin
                    state_d = last_row ? S_DONE : S_HANDOFF;
                end
            end
            S_HANDOFF: state_d = S_ROW;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered below
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        fidx_d  = fidx_q;
        cwr_d   = 1'b0;
        csel_d  = '0;
        caddr_d = '0;
        cdata_d = '0;
        go_d    = 1'b0;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        buf_we  = 1'b0;
        // Busy stays up through the cycle that carries o_done
        busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    row_d  = '0;
                    col_d  = '0;
                    fidx_d = '0;
                    ovr_d  = bus.i_valid;
                end else if (bus.i_valid) begin
                    ovr_d  = 1'b1;
                end
            end
            S_ROW: begin
                if (bus.i_valid) begin
                    cwr_d   = 1'b1;
                    csel_d  = SEL0;
                    caddr_d = CAW'({row_q, col_q});
                    cdata_d = CDW'(bus.i_data_0);
                    buf_we  = 1'b1;
                    col_d   = col_q + COL_W'(1);
                end
            end
            S_FLUSH: begin
                cwr_d   = 1'b1;
                csel_d  = SEL1;
                caddr_d = CAW'({row_q, fidx_q});
                cdata_d = CDW'(buf_rd);
                fidx_d  = fidx_q + COL_W'(1);
                if (bus.i_valid) begin
                    ovr_d = 1'b1;
                end
            end
            S_HANDOFF: begin
                go_d  = 1'b1;
                row_d = row_q + ROW_W'(1);
                if (bus.i_valid) begin
                    ovr_d = 1'b1;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                if (bus.i_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                row_d = '0;
            end
        endcase
    end

    // Counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q   <= '0;
            col_q   <= '0;
            fidx_q  <= '0;
            cwr_q   <= 1'b0;
            csel_q  <= '0;
            caddr_q <= '0;
            cdata_q <= '0;
            busy_q  <= 1'b0;
            go_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            fidx_q  <= fidx_d;
            cwr_q   <= cwr_d;
            csel_q  <= csel_d;
            caddr_q <= caddr_d;
            cdata_q <= cdata_d;
            busy_q  <= busy_d;
            go_q    <= go_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Kernel-1 row buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (buf_we) begin
            row_buf[col_q] <= bus.i_data_1;
        end
    end

    assign bus.o_cwr      = cwr_q;
    assign bus.o_csel     = csel_q;
    assign bus.o_caddr_wr = caddr_q;
    assign bus.o_cdata_wr = cdata_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_go_down  = go_q;
    assign bus.o_done     = done_q;
    assign bus.o_overrun  = ovr_q;

endmodule

// File: tb/tb_layer0_writer.sv
// Bench for layer0_writer: vector table for single-cycle behaviour, then
// whole-frame sequences checked by a write-order scoreboard.
module tb_layer0_writer;
    localparam int COLS = 64;
    localparam int ROWS = 64;

    bit clk = 1'b0;
    bit reset = 1'b0;
    int cyc = 0;

    layer0_writer_if #(.DW(19)) bus ();

    layer0_writer #(.COLS(COLS), .ROWS(ROWS), .DW(19)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    int  tb_mode = 0;       // 0: addr-tagged data, 1: 0x7FFFF / 0
    int  last_t  = 0;       // edge at which the latest row valid was sampled
    bit  sb_clr  = 1'b0;
    int  wr_cnt, wr_err, gd_cnt, done_cnt, tm_err, idle_err, t63;
    int  bad_n, bad_sel, bad_addr, bad_data;

    always @(negedge clk) begin
        if (sb_clr) begin
            wr_cnt = 0; wr_err = 0; gd_cnt = 0; done_cnt = 0;
            tm_err = 0; idle_err = 0; t63 = 0;
            bad_n = 0; bad_sel = 0; bad_addr = 0; bad_data = 0;
        end else begin
            if (bus.o_cwr) begin
                int r, j, es, ea, ed;
                bit ok;
                r  = wr_cnt / (2 * COLS);
                j  = wr_cnt % (2 * COLS);
                es = (j < COLS) ? 1 : 2;
                ea = r * COLS + (j % COLS);
                if (tb_mode == 1) ed = (j < COLS) ? 'h7FFFF : 0;
                else              ed = (j < COLS) ? ea : ('h40000 | ea);
                ok = (bus.o_csel == 3'(es)) && (bus.o_caddr_wr == 12'(ea)) &&
                     (bus.o_cdata_wr == 20'(ed));
                if (j == COLS - 1) t63 = cyc;
                if (j >= COLS && cyc != t63 + (j - COLS + 1)) ok = 1'b0;
                if (!ok) begin
                    if (wr_err == 0) begin
                        bad_n = wr_cnt; bad_sel = int'(bus.o_csel);
                        bad_addr = int'(bus.o_caddr_wr); bad_data = int'(bus.o_cdata_wr);
                    end
                    wr_err++;
                end
                wr_cnt++;
            end else if (bus.o_csel != 3'd0 || bus.o_caddr_wr != 12'd0) begin
                idle_err++;
            end
            if (bus.o_go_down) begin
                gd_cnt++;
                if (cyc - last_t != COLS + 1) tm_err++;
            end
            if (bus.o_done) begin
                done_cnt++;
                if (cyc - last_t != COLS + 1) tm_err++;
            end
        end
    end

    task automatic clear_sb();
        sb_clr = 1'b1;
        @(negedge clk);
        #1;
        sb_clr = 1'b0;
    endtask

    int to_err = 0;

    task automatic wait_sig(input bit want_done);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (want_done ? bus.o_done : bus.o_go_down) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) to_err++;
    endtask

    task automatic send_row(input int r, input int max_gap, input bit inj_start);
        for (int c = 0; c < COLS; c++) begin
            int g;
            logic [18:0] a;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) tick();
            a = 19'(r * COLS + c);
            bus.i_valid  = 1'b1;
            bus.i_data_0 = (tb_mode == 1) ? 19'h7FFFF : a;
            bus.i_data_1 = (tb_mode == 1) ? 19'h0 : (19'h40000 | a);
            bus.i_start  = inj_start && (c == 20);
            tick();
            last_t = cyc;
            bus.i_valid = 1'b0;
            bus.i_start = 1'b0;
        end
    endtask

    task automatic run_frame(input string p, input int max_gap,
                             input int inj_flush_row, input int inj_start_row);
        tb_mode = 0;
        to_err  = 0;
        clear_sb();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            send_row(r, max_gap, r == inj_start_row);
            if (r == inj_flush_row) begin
                repeat (10) tick();
                bus.i_valid  = 1'b1;
                bus.i_data_0 = 19'h1234;
                bus.i_data_1 = 19'h5678;
                tick();
                bus.i_valid = 1'b0;
                check({p, "_ovr_set"}, bus.o_overrun, 1);
            end
            wait_sig(r == ROWS - 1);
        end
        check({p, "_busy_in_done"}, bus.o_busy, 1);
        tick();
        tick();
        check({p, "_busy_after"}, bus.o_busy, 0);
    endtask

    task automatic frame_checks(input string p, input int exp_wr, input int exp_gd,
                                input int exp_done, input int exp_ovr);
        check({p, "_wr_count"}, wr_cnt, exp_wr);
        check($sformatf("%s_writes_bad(first n=%0d sel=%0d addr=%0h data=%0h)",
                        p, bad_n, bad_sel, bad_addr, bad_data), wr_err, 0);
        check({p, "_go_down_count"}, gd_cnt, exp_gd);
        check({p, "_done_count"}, done_cnt, exp_done);
        check({p, "_pulse_timing_bad"}, tm_err, 0);
        check({p, "_idle_bus_bad"}, idle_err, 0);
        check({p, "_wait_timeouts"}, to_err, 0);
        check({p, "_overrun"}, bus.o_overrun, exp_ovr);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          start;
        bit          valid;
        logic [18:0] d0;
        logic [18:0] d1;
        bit          cwr;
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
        bit          busy;
        bit          go;
        bit          done;
        bit          ovr;
    } vec_t;

    vec_t vt[13];

    initial begin
        //          rst  st   vld  d0         d1         cwr  sel   addr    data        busy go   done ovr
        vt[0]  = '{1'b0, 1'b0, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 19'h5,     19'h6, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 19'h123,   19'h456, 1'b1, 3'd1, 12'd0, 20'h123, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 19'h7FFFF, 19'h1, 1'b1, 3'd1, 12'd1, 20'h7FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 19'h2,     19'h3, 1'b1, 3'd1, 12'd2, 20'h2,     1'b1, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 19'h9,     19'h9, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1'b1, 19'h4,     19'h4, 1'b0, 3'd0, 12'd0, 20'h0,     1'b1, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b1, 19'h11,    19'h22, 1'b1, 3'd1, 12'd0, 20'h11,   1'b1, 1'b0, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 19'h0,     19'h0, 1'b0, 3'd0, 12'd0, 20'h0,     1'b0, 1'b0, 1'b0, 1'b0};

        bus.i_start = 1'b0; bus.i_valid = 1'b0;
        bus.i_data_0 = '0;  bus.i_data_1 = '0;
        reset = 1'b0;
        repeat (3) tick();

        // Single-cycle behaviour from the table
        for (int i = 0; i < 13; i++) begin
            logic [39:0] act, exp;
            logic [19:0] dm;
            reset        = vt[i].rst_n;
            bus.i_start  = vt[i].start;
            bus.i_valid  = vt[i].valid;
            bus.i_data_0 = vt[i].d0;
            bus.i_data_1 = vt[i].d1;
            tick();
            dm  = (vt[i].cwr || !vt[i].rst_n) ? bus.o_cdata_wr : vt[i].data;
            act = {bus.o_cwr, bus.o_csel, bus.o_caddr_wr, dm,
                   bus.o_busy, bus.o_go_down, bus.o_done, bus.o_overrun};
            exp = {vt[i].cwr, vt[i].sel, vt[i].addr, vt[i].data,
                   vt[i].busy, vt[i].go, vt[i].done, vt[i].ovr};
            check($sformatf("vec%0d", i), act, exp);
        end
        bus.i_start = 1'b0; bus.i_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Full frame, back-to-back valids
        run_frame("f1", 0, -1, -1);
        frame_checks("f1", 2 * ROWS * COLS, ROWS - 1, 1, 0);

        // Full frame, random 0-5 cycle gaps
        run_frame("f2", 5, -1, -1);
        frame_checks("f2", 2 * ROWS * COLS, ROWS - 1, 1, 0);

        // Row 0 with saturated kernel-0 and zero kernel-1 data
        tb_mode = 1;
        to_err  = 0;
        clear_sb();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        send_row(0, 0, 1'b0);
        wait_sig(1'b0);
        tick();
        frame_checks("r0", 2 * COLS, 1, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Stray valid in the 10th flush cycle of row 5
        run_frame("f4", 0, 5, -1);
        frame_checks("f4", 2 * ROWS * COLS, ROWS - 1, 1, 1);

        // Reset in the 30th flush cycle of row 2
        tb_mode = 0;
        to_err  = 0;
        clear_sb();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        for (int r = 0; r < 2; r++) begin
            send_row(r, 0, 1'b0);
            wait_sig(1'b0);
        end
        send_row(2, 0, 1'b0);
        repeat (30) tick();
        reset = 1'b0;
        tick();
        check("rst_mid_outputs",
              {bus.o_cwr, bus.o_csel, bus.o_caddr_wr, bus.o_cdata_wr,
               bus.o_busy, bus.o_go_down, bus.o_done, bus.o_overrun}, 0);
        reset = 1'b1;
        tick();
        check("rst_mid_idle", bus.o_busy, 0);
        check("rst_mid_timeouts", to_err, 0);

        // Fresh frame after the abandoned one, with a stray i_start in row 3
        run_frame("f6", 0, -1, 3);
        frame_checks("f6", 2 * ROWS * COLS, ROWS - 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
